// File: rtl/div_pkg.sv
// Shared types and sizing for the 32/16 restoring divider.
package div_pkg;

  localparam int QW = 16;
  localparam int DW = 32;
  localparam int CW = $clog2(QW);
  localparam logic [QW-1:0] QMAX = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [QW-1:0] p,
  input  logic          din,
  input  logic [QW-1:0] dvs,
  output logic [QW-1:0] p_next,
  output logic          qbit
);

  logic [QW:0] shifted;

  // The incoming partial remainder is always below the divisor, so the
  // post-subtract value fits back into QW bits.
  always_comb begin
    shifted = {p, din};
    qbit    = (shifted >= {1'b0, dvs});
    p_next  = qbit ? QW'(shifted - {1'b0, dvs}) : shifted[QW-1:0];
  end

endmodule

// File: rtl/div_32x16_restoring_seq.sv
// Sequential restoring divider, 32/16 -> 16-bit quotient and remainder, one bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands with truncating division.
module div_32x16_restoring_seq
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [QW-1:0] remainder,
  output logic          dbz,
  output logic          ovf
);

  state_t          state, state_nxt;
  logic            chk;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   a_q;
  logic [QW-1:0]   b_q;
  logic [QW-1:0]   p;
  logic [QW-1:0]   lo;
  logic [QW-1:0]   dvs;
  logic [DW-1:0]   a_mag;
  logic [QW-1:0]   b_mag;
  logic [QW-1:0]   p_nxt;
  logic            qbit;
  logic            pre_dbz, pre_ovf;
  logic [QW-1:0]   ovf_q;

`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign r_neg = a_q[DW-1];
  assign q_neg = a_q[DW-1] ^ b_q[QW-1];
  assign a_mag = a_q[DW-1] ? -a_q : a_q;
  assign b_mag = b_q[QW-1] ? -b_q : b_q;
  assign ovf_q = q_neg ? 16'h8000 : 16'h7FFF;
`else
  assign a_mag = a_q;
  assign b_mag = b_q;
  assign ovf_q = QMAX;
`endif

  assign pre_dbz   = (b_q == '0);
  assign pre_ovf   = !pre_dbz && (a_mag[DW-1:QW] >= b_mag);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  div_step u_step (
    .p      (p),
    .din    (lo[QW-1]),
    .dvs    (dvs),
    .p_next (p_nxt),
    .qbit   (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state is assigned a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = CALC;
      CALC: begin
        if (chk) begin
          if (pre_dbz || pre_ovf) state_nxt = DONE;
        end else if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
          state_nxt = SIGN;
`else
          state_nxt = DONE;
`endif
        end
      end
      SIGN: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first CALC cycle (chk set) screens for divide-by-zero and overflow
  // before the 16 shift/subtract iterations start.
  // NOTE: all state here uses non-blocking assignments; every register, including operands, is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk       <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p         <= '0;
      lo        <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= dividend;
          b_q <= divisor;
          chk <= 1'b1;
          dbz <= 1'b0;
          ovf <= 1'b0;
        end
        CALC: begin
          if (chk) begin
            chk <= 1'b0;
            if (pre_dbz) begin
              dbz       <= 1'b1;
              quotient  <= QMAX;
              remainder <= a_q[QW-1:0];
            end else if (pre_ovf) begin
              ovf       <= 1'b1;
              quotient  <= ovf_q;
              remainder <= '0;
            end else begin
              p   <= a_mag[DW-1:QW];
              lo  <= a_mag[QW-1:0];
              dvs <= b_mag;
              cnt <= CW'(QW - 1);
            end
          end else begin
            // lo shifts dividend bits out the top and quotient bits in the bottom.
            p  <= p_nxt;
            lo <= {lo[QW-2:0], qbit};
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
              quotient  <= {lo[QW-2:0], qbit};
              remainder <= p_nxt;
            end
          end
        end
`ifdef DIV_SIGNED_EN
        SIGN: begin
          if (q_neg && (quotient > 16'h8000)) begin
            ovf       <= 1'b1;
            quotient  <= 16'h8000;
            remainder <= '0;
          end else if (!q_neg && (quotient > 16'h7FFF)) begin
            ovf       <= 1'b1;
            quotient  <= 16'h7FFF;
            remainder <= '0;
          end else begin
            quotient  <= q_neg ? -quotient : quotient;
            remainder <= r_neg ? -remainder : remainder;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
